reg_display_scanner: RTL and testbench

//  Drives a 4-digit multiplexed 7-segment display from the CPU's 16-bit debug taps (a0, v0, sp, ra).

---
 rtl/reg_display_pkg.sv | 23 ++
 rtl/hex_to_seg7.sv | 17 +
 rtl/reg_display_scanner.sv | 155 +++++++++++++++
 tb/tb_reg_display_scanner.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/reg_display_pkg.sv
// Shared constants for the register display scanner: register indices and hex glyphs.
// Latency: n/a (package only).
// Backpressure: n/a.
//
// Contents:
//   REG_A0..REG_RA : sel encodings for the four CPU debug taps
//   SEG7_GLYPH     : active-high {g,f,e,d,c,b,a} patterns for hex digits 0-F
package reg_display_pkg;

   localparam logic [1:0] REG_A0 = 2'd0;
   localparam logic [1:0] REG_V0 = 2'd1;
   localparam logic [1:0] REG_SP = 2'd2;
   localparam logic [1:0] REG_RA = 2'd3;

   // Packed so that SEG7_GLYPH[n] is the glyph for hex digit n; element 15 is listed first.
   localparam logic [15:0][6:0] SEG7_GLYPH = {
      7'h71, 7'h79, 7'h5E, 7'h39,   // F E d C
      7'h7C, 7'h77, 7'h6F, 7'h7F,   // b A 9 8
      7'h07, 7'h7D, 7'h6D, 7'h66,   // 7 6 5 4
      7'h4F, 7'h5B, 7'h06, 7'h3F    // 3 2 1 0
   };

endpackage

// File: rtl/hex_to_seg7.sv
// Hex nibble to 7-segment pattern decoder, active-high {g,f,e,d,c,b,a}.
// Latency: combinational, 0 cycles.
// Backpressure: none.
//
// Ports:
//   nibble : hex value 0-F to display
//   seg7   : active-high segment pattern, bit 0 = segment a
module hex_to_seg7
   import reg_display_pkg::*;
(
   input  logic [3:0] nibble,
   output logic [6:0] seg7
);

   assign seg7 = SEG7_GLYPH[nibble];

endmodule

// File: rtl/reg_display_scanner.sv
// Multiplexed 4-digit 7-segment scanner showing one of four CPU debug taps, button-selected.
// Latency: an/seg lag the internal digit counter by 1 cycle; a new value appears at the next frame.
// Backpressure: none; free-running scan, the button is sampled continuously.
//
// Ports:
//   clk, reset       : system clock, synchronous active-high reset
//   a0, v0, sp, ra   : 16-bit CPU register taps
//   btn_next         : raw asynchronous push-button, high = pressed
//   sel              : selected register index (0=a0 1=v0 2=sp 3=ra)
//   an               : one-hot digit enables, an[0] = rightmost digit (ACTIVE_LOW polarity)
//   seg              : {dp,g,f,e,d,c,b,a} (ACTIVE_LOW polarity); dp marks digit index == sel
module reg_display_scanner
   import reg_display_pkg::*;
#(
   parameter int SCAN_DIV        = 100000,
   parameter int DEBOUNCE_CYCLES = 1000000,
   parameter bit ACTIVE_LOW      = 1'b1
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [15:0] a0,
   input  logic [15:0] v0,
   input  logic [15:0] sp,
   input  logic [15:0] ra,
   input  logic        btn_next,
   output logic [1:0]  sel,
   output logic [3:0]  an,
   output logic [7:0]  seg
);

   localparam int SCAN_W = $clog2(SCAN_DIV);
   localparam int DB_W   = $clog2(DEBOUNCE_CYCLES);

   localparam logic [SCAN_W-1:0] SCAN_LAST = SCAN_W'(SCAN_DIV - 1);
   localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 1);

   // XOR masks applied in the output register to reach board polarity.
   localparam logic [3:0] AN_INV  = ACTIVE_LOW ? 4'hF  : 4'h0;
   localparam logic [7:0] SEG_INV = ACTIVE_LOW ? 8'hFF : 8'h00;

   localparam logic [3:0] AN_RESET  = AN_INV ^ 4'b0001;
   localparam logic [7:0] SEG_RESET = SEG_INV ^ {1'b0, SEG7_GLYPH[0]};

   // ---------------------------------------------------------------
   // Button path
   // ---------------------------------------------------------------
   logic            sync1;
   logic            sync2;
   logic [1:0]      sync_primed;
   logic            db_level;
   logic [DB_W-1:0] db_cnt;
   logic            armed;
   logic            db_accept;
   logic            db_rise;

   assign db_accept = (sync2 != db_level) && (db_cnt == DB_LAST);
   assign db_rise   = db_accept && sync2 && armed;

   always_ff @(posedge clk) begin
      if (reset) begin
         sync1       <= 1'b0;
         sync2       <= 1'b0;
         sync_primed <= 2'b00;
         db_level    <= 1'b0;
         db_cnt      <= '0;
         armed       <= 1'b0;
         sel         <= REG_A0;
      end else begin
         sync1       <= btn_next;
         sync2       <= sync1;
         // Marks when sync2 holds a real sample instead of its reset zero.
         sync_primed <= {sync_primed[0], 1'b1};

         // Count only while the synchronized level disagrees with the accepted level.
         if (sync2 == db_level) begin
            db_cnt <= '0;
         end else if (db_cnt == DB_LAST) begin
            db_cnt   <= '0;
            db_level <= sync2;
         end else begin
            db_cnt <= db_cnt + DB_W'(1);
         end

         // A button held through reset must be seen released before a press counts.
         if (sync_primed[1] && !sync2 && !db_level) begin
            armed <= 1'b1;
         end

         if (db_rise) begin
            sel <= sel + 2'd1;
         end
      end
   end

   // ---------------------------------------------------------------
   // Scan, snapshot and output register
   // ---------------------------------------------------------------
   logic [SCAN_W-1:0] scan_cnt;
   logic [1:0]        digit;
   logic [1:0]        sel_prev;
   logic [15:0]       snapshot;
   logic [15:0]       sel_value;
   logic              scan_last;
   logic              frame_wrap;
   logic [3:0]        nibble;
   logic [6:0]        glyph;

   always_comb begin
      sel_value = a0;
      case (sel)
         REG_A0:  sel_value = a0;
         REG_V0:  sel_value = v0;
         REG_SP:  sel_value = sp;
         REG_RA:  sel_value = ra;
         default: sel_value = a0;
      endcase
   end

   assign scan_last  = (scan_cnt == SCAN_LAST);
   assign frame_wrap = scan_last && (digit == 2'd3);
   assign nibble     = snapshot[{digit, 2'b00} +: 4];

   hex_to_seg7 u_hex_to_seg7 (
      .nibble (nibble),
      .seg7   (glyph)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         scan_cnt <= '0;
         digit    <= 2'd0;
         sel_prev <= REG_A0;
         snapshot <= 16'h0000;
         an       <= AN_RESET;
         seg      <= SEG_RESET;
      end else begin
         scan_cnt <= scan_last ? '0 : scan_cnt + SCAN_W'(1);
         if (scan_last) begin
            digit <= digit + 2'd1;
         end

         // A sel change reloads one cycle later; if it coincided with a frame wrap,
         // the wrap captured the old register and this reload corrects it.
         sel_prev <= sel;
         if ((sel != sel_prev) || frame_wrap) begin
            snapshot <= sel_value;
         end

         // an and seg come from the same digit value, so they always agree.
         an  <= AN_INV ^ (4'b0001 << digit);
         seg <= SEG_INV ^ {(digit == sel), glyph};
      end
   end

endmodule

// File: tb/tb_reg_display_scanner.sv
module tb_reg_display_scanner;

   logic        clk = 1'b0;
   logic        reset;
   logic [15:0] a0, v0, sp, ra;
   logic        btn_next;
   logic [1:0]  sel;
   logic [3:0]  an;
   logic [7:0]  seg;

   int total = 0;
   int bad   = 0;
   logic [1:0] exp_sel;

   typedef struct packed {
      logic [15:0]     a0;
      logic [15:0]     v0;
      logic [15:0]     sp;
      logic [15:0]     ra;
      logic [1:0]      sel;
      logic [3:0][7:0] segs;   // expected active-low seg per digit, dp included
   } vec_t;

   typedef struct packed {
      logic [3:0] an;
      logic [7:0] seg;
   } obs_t;

   vec_t vecs [5];
   obs_t sb [$];

   always #5 clk = ~clk;

   reg_display_scanner #(
      .SCAN_DIV        (4),
      .DEBOUNCE_CYCLES (8),
      .ACTIVE_LOW      (1'b1)
   ) dut (
      .clk      (clk),
      .reset    (reset),
      .a0       (a0),
      .v0       (v0),
      .sp       (sp),
      .ra       (ra),
      .btn_next (btn_next),
      .sel      (sel),
      .an       (an),
      .seg      (seg)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s: got %0h, want %0h", name, act, req);
      end
   endtask

   task automatic drive_taps(input vec_t v);
      a0 = v.a0;
      v0 = v.v0;
      sp = v.sp;
      ra = v.ra;
   endtask

   // Returns at the first negedge where an has just stepped from digit 3 to digit 0.
   task automatic wait_frame_start();
      logic [3:0] prev;
      bit found;
      found = 1'b0;
      prev  = an;
      for (int i = 0; i < 80 && !found; i++) begin
         @(negedge clk);
         if (prev == 4'b0111 && an == 4'b1110) found = 1'b1;
         prev = an;
      end
      total++;
      if (!found) begin
         bad++;
         $display("FAIL frame_start: an never went 0111->1110 within 80 cycles (an=%b)", an);
      end
   endtask

   // Checks a whole frame (4 digits x 4 cycles). Optionally drives a0 to new_a0
   // as digit chg_digit starts being shown.
   task automatic check_frame(input vec_t v, input int chg_digit, input logic [15:0] new_a0);
      obs_t e;
      logic [3:0] one;
      wait_frame_start();
      for (int d = 0; d < 4; d++) begin
         one = 4'b0001 << d;
         for (int k = 0; k < 4; k++) begin
            e.an  = ~one;
            e.seg = v.segs[d];
            sb.push_back(e);
         end
      end
      for (int d = 0; d < 4; d++) begin
         if (d == chg_digit) a0 = new_a0;
         for (int k = 0; k < 4; k++) begin
            e = sb.pop_front();
            check($sformatf("frame_an d%0d c%0d", d, k), {28'd0, an}, {28'd0, e.an});
            check($sformatf("frame_seg d%0d c%0d", d, k), {24'd0, seg}, {24'd0, e.seg});
            @(negedge clk);
         end
      end
   endtask

   // Clean press: 20 cycles held, 20 released. Expects one increment ~10 cycles in.
   task automatic press();
      int lat;
      lat = -1;
      btn_next = 1'b1;
      for (int i = 1; i <= 20; i++) begin
         @(negedge clk);
         if (lat < 0 && sel !== exp_sel) lat = i;
      end
      exp_sel = exp_sel + 2'd1;
      check($sformatf("press_latency(lat=%0d)", lat), {31'd0, (lat >= 8 && lat <= 12)}, 32'd1);
      check("sel_after_hold", {30'd0, sel}, {30'd0, exp_sel});
      btn_next = 1'b0;
      repeat (20) @(negedge clk);
      check("sel_after_release", {30'd0, sel}, {30'd0, exp_sel});
   endtask

   initial begin
      vec_t v;

      vecs[0] = '{a0:16'h1234, v0:16'hBEEF, sp:16'h5A69, ra:16'hFFFF, sel:2'd0,
                  segs:{8'hF9, 8'hA4, 8'hB0, 8'h19}};
      vecs[1] = '{a0:16'h1234, v0:16'hBEEF, sp:16'h5A69, ra:16'hFFFF, sel:2'd1,
                  segs:{8'h83, 8'h86, 8'h06, 8'h8E}};
      vecs[2] = '{a0:16'h1234, v0:16'hBEEF, sp:16'h5A69, ra:16'hFFFF, sel:2'd2,
                  segs:{8'h92, 8'h08, 8'h82, 8'h90}};
      vecs[3] = '{a0:16'h1234, v0:16'hBEEF, sp:16'h5A69, ra:16'hFFFF, sel:2'd3,
                  segs:{8'h0E, 8'h8E, 8'h8E, 8'h8E}};
      vecs[4] = '{a0:16'h0000, v0:16'hBEEF, sp:16'h5A69, ra:16'hFFFF, sel:2'd0,
                  segs:{8'hC0, 8'hC0, 8'hC0, 8'h40}};

      // Reset state
      reset    = 1'b1;
      btn_next = 1'b0;
      exp_sel  = 2'd0;
      drive_taps(vecs[0]);
      repeat (3) @(negedge clk);
      check("reset_an",  {28'd0, an},  32'h0000000E);
      check("reset_seg", {24'd0, seg}, 32'h000000C0);
      check("reset_sel", {30'd0, sel}, 32'd0);
      reset = 1'b0;

      // Table: press up to each entry's sel, then verify a full frame
      for (int i = 0; i < 5; i++) begin
         drive_taps(vecs[i]);
         for (int n = 0; n < 4 && exp_sel != vecs[i].sel; n++) press();
         check($sformatf("table_sel[%0d]", i), {30'd0, sel}, {30'd0, vecs[i].sel});
         check_frame(vecs[i], -1, 16'h0000);
      end

      // Short glitches never pass the debouncer
      for (int p = 0; p < 5; p++) begin
         btn_next = 1'b1;
         repeat (5) @(negedge clk);
         btn_next = 1'b0;
         repeat (3) @(negedge clk);
         check($sformatf("glitch_sel[%0d]", p), {30'd0, sel}, {30'd0, exp_sel});
      end
      repeat (20) @(negedge clk);
      check("glitch_sel_final", {30'd0, sel}, {30'd0, exp_sel});

      // a0 changes mid-frame: current frame keeps the old snapshot
      v = vecs[4];
      check_frame(v, 1, 16'hABCD);
      v.a0   = 16'hABCD;
      v.segs = {8'h88, 8'h83, 8'hC6, 8'h21};
      check_frame(v, -1, 16'hABCD);

      // Reset mid-frame with the button held
      press();
      press();
      check("pre_reset_sel", {30'd0, sel}, 32'd2);
      btn_next = 1'b1;
      repeat (3) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      exp_sel = 2'd0;
      check("midreset_sel", {30'd0, sel}, 32'd0);
      check("midreset_an",  {28'd0, an},  32'h0000000E);
      check("midreset_seg", {24'd0, seg}, 32'h000000C0);
      repeat (2) @(negedge clk);
      reset = 1'b0;
      repeat (30) @(negedge clk);
      check("held_through_reset_sel", {30'd0, sel}, 32'd0);
      btn_next = 1'b0;
      repeat (30) @(negedge clk);
      check("release_after_reset_sel", {30'd0, sel}, 32'd0);
      press();
      check("repress_after_reset_sel", {30'd0, sel}, 32'd1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
